// File: rtl/apb4_pkg.sv
// Shared definitions for the APB4 command master: FSM encoding, PPROT bit
// positions and the default PREADY timeout.
package apb4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETUP  = 2'd1,
    ST_ACCESS = 2'd2,
    ST_RESP   = 2'd3
  } apb4_state_e;

  localparam int PPROT_PRIV   = 0;
  localparam int PPROT_NONSEC = 1;
  localparam int PPROT_INSTR  = 2;

  localparam int APB4_DEFAULT_TIMEOUT = 256;

endpackage

// File: rtl/apb4_cmd_master.sv
// APB4 requester: turns one valid/ready command at a time into a SETUP/ACCESS
// sequence and returns read data / error status on a valid/ready response port.
module apb4_cmd_master
  import apb4_pkg::*;
#(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int DS      = DW / 8,
  parameter int TIMEOUT = APB4_DEFAULT_TIMEOUT,
  parameter int CW      = 16
) (
  input  logic          PCLK,
  input  logic          PRESET,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_write,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [DS-1:0] req_strb,
  input  logic [2:0]    req_prot,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata,
  output logic          rsp_err,
  output logic          PSEL,
  output logic          PENABLE,
  output logic [AW-1:0] PADDR,
  output logic          PWRITE,
  output logic [DW-1:0] PWDATA,
  output logic [DS-1:0] PSTRB,
  output logic [2:0]    PPROT,
  input  logic [DW-1:0] PRDATA,
  input  logic          PREADY,
  input  logic          PSLVERR
);

  apb4_state_e   r_state;
  logic [CW-1:0] r_cnt;
  logic          r_psel;
  logic          r_penable;
  logic [AW-1:0] r_paddr;
  logic          r_pwrite;
  logic [DW-1:0] r_pwdata;
  logic [DS-1:0] r_pstrb;
  logic [2:0]    r_pprot;
  logic          r_rsp_valid;
  logic [DW-1:0] r_rsp_rdata;
  logic          r_rsp_err;
  logic          w_timeout;

  // Counter value TIMEOUT-1 in the current ACCESS cycle means this is the
  // TIMEOUT-th consecutive wait cycle; a TIMEOUT of 0 never fires.
  assign w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
  assign req_ready = (r_state == ST_IDLE) && !PRESET;

  always_ff @(posedge PCLK or posedge PRESET) begin
    if (PRESET) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_psel      <= 1'b0;
      r_penable   <= 1'b0;
      r_paddr     <= '0;
      r_pwrite    <= 1'b0;
      r_pwdata    <= '0;
      r_pstrb     <= '0;
      r_pprot     <= '0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_rsp_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (req_valid) begin
            r_paddr   <= req_addr;
            r_pwrite  <= req_write;
            r_pwdata  <= req_write ? req_wdata : '0;
            r_pstrb   <= req_write ? req_strb : '0;
            r_pprot   <= req_prot;
            r_psel    <= 1'b1;
            r_penable <= 1'b0;
            r_state   <= ST_SETUP;
          end
        end
        ST_SETUP: begin
          r_penable <= 1'b1;
          r_cnt     <= '0;
          r_state   <= ST_ACCESS;
        end
        ST_ACCESS: begin
          if (PREADY) begin
            r_rsp_rdata <= r_pwrite ? '0 : PRDATA;
            r_rsp_err   <= PSLVERR;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_RESP;
          end else if (w_timeout) begin
            r_rsp_rdata <= '0;
            r_rsp_err   <= 1'b1;
            r_rsp_valid <= 1'b1;
            r_psel      <= 1'b0;
            r_penable   <= 1'b0;
            r_state     <= ST_RESP;
          end else begin
            r_cnt <= r_cnt + CW'(1);
          end
        end
        ST_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign PSEL      = r_psel;
  assign PENABLE   = r_penable;
  assign PADDR     = r_paddr;
  assign PWRITE    = r_pwrite;
  assign PWDATA    = r_pwdata;
  assign PSTRB     = r_pstrb;
  assign PPROT     = r_pprot;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_apb4_cmd_master.sv
// Bench for apb4_cmd_master: a small APB memory slave with configurable wait
// states / error / stuck-PREADY, a table of directed vectors and random traffic.
module tb_apb4_cmd_master;
  import apb4_pkg::*;

  localparam int TO = 8;
  localparam logic [31:0] BASE = 32'h1000_0040;

  logic        clk = 1'b0;
  logic        PRESET;
  logic        req_valid, req_ready, req_write;
  logic [31:0] req_addr, req_wdata;
  logic [3:0]  req_strb;
  logic [2:0]  req_prot;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [31:0] rsp_rdata;
  logic        PSEL, PENABLE, PWRITE, PREADY, PSLVERR;
  logic [31:0] PADDR, PWDATA, PRDATA;
  logic [3:0]  PSTRB;
  logic [2:0]  PPROT;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  apb4_cmd_master #(.AW(32), .DW(32), .DS(4), .TIMEOUT(TO), .CW(16)) dut (
    .PCLK(clk), .PRESET(PRESET),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_strb(req_strb), .req_prot(req_prot),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .PSEL(PSEL), .PENABLE(PENABLE), .PADDR(PADDR), .PWRITE(PWRITE), .PWDATA(PWDATA),
    .PSTRB(PSTRB), .PPROT(PPROT), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR)
  );

  // Slave: PREADY rises after s_waits ACCESS cycles unless stuck; no write on error.
  int          s_waits = 0;
  logic        s_err = 1'b0;
  logic        s_stuck = 1'b0;
  int          s_wcnt = 0;
  logic [31:0] slave_mem [16] = '{default: 32'h0};

  assign PREADY  = PSEL && PENABLE && !s_stuck && (s_wcnt == s_waits);
  assign PSLVERR = s_err;
  assign PRDATA  = slave_mem[PADDR[5:2]];

  always @(posedge clk) begin
    if (PSEL && PENABLE && !PREADY) s_wcnt <= s_wcnt + 1;
    else s_wcnt <= 0;
    if (PSEL && PENABLE && PREADY && PWRITE && !s_err)
      for (int b = 0; b < 4; b++)
        if (PSTRB[b]) slave_mem[PADDR[5:2]][8*b +: 8] <= PWDATA[8*b +: 8];
  end

  // Reference memory, indexed by word offset from BASE.
  logic [31:0] model_mem [16] = '{default: 32'h0};

  typedef struct {
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    logic [2:0]  prot;
    int          waits;
    logic        err;
    logic        stuck;
    int          hold;
    logic [31:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
  } vec_t;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic run_txn(input vec_t v);
    int lat;
    int acc;
    bit done;
    logic [31:0] rd;
    logic er;
    @(negedge clk);
    s_waits = v.waits; s_err = v.err; s_stuck = v.stuck;
    req_valid = 1'b1; req_write = v.wr; req_addr = v.addr;
    req_wdata = v.wdata; req_strb = v.strb; req_prot = v.prot;
    chk("req_ready_idle", req_ready, 1);
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_wdata = $urandom; req_addr = $urandom;
    lat = 1;
    chk("setup_phase", {PSEL, PENABLE}, 2'b10);
    acc = 0; done = 0;
    while (!done && lat < 100) begin
      @(negedge clk);
      lat++;
      if (rsp_valid) done = 1;
      else begin
        acc++;
        chk("access_phase", {PSEL, PENABLE}, 2'b11);
        chk("paddr_stable", PADDR, v.addr);
        chk("pwdata", PWDATA, v.wr ? v.wdata : 32'h0);
        chk("pstrb", PSTRB, v.wr ? v.strb : 4'h0);
        chk("pwrite_pprot", {PWRITE, PPROT}, {v.wr, v.prot});
      end
    end
    chk("rsp_seen", done, 1);
    chk("latency", lat, v.exp_lat);
    chk("access_cycles", acc, v.exp_lat - 2);
    chk("rsp_rdata", rsp_rdata, v.exp_rdata);
    chk("rsp_err", rsp_err, v.exp_err);
    chk("psel_after", {PSEL, PENABLE}, 2'b00);
    rd = rsp_rdata; er = rsp_err;
    for (int h = 0; h < v.hold; h++) begin
      @(negedge clk);
      chk("hold_fields", {rsp_valid, rsp_err, rsp_rdata}, {1'b1, er, rd});
      chk("hold_bus_idle", {req_ready, PSEL}, 2'b00);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk("rsp_done", {rsp_valid, req_ready}, 2'b01);
    if (v.wr && !v.err && !v.stuck)
      for (int b = 0; b < 4; b++)
        if (v.strb[b]) model_mem[(v.addr - BASE) / 4][8*b +: 8] = v.wdata[8*b +: 8];
    $display("txn wr=%0d addr=%h wdata=%h strb=%h waits=%0d err=%0d stuck=%0d -> rdata=%h err=%0d lat=%0d",
             v.wr, v.addr, v.wdata, v.strb, v.waits, v.err, v.stuck, rd, er, lat);
  endtask

  vec_t tbl [12];
  vec_t v;

  initial begin
    // wr addr wdata strb prot waits err stuck hold | exp_rdata exp_err exp_lat
    tbl[0]  = '{1, 32'h1000_0040, 32'hDEAD_BEEF, 4'hF, 3'(1 << PPROT_PRIV),   0, 0, 0, 0, 32'h0,         0, 3};
    tbl[1]  = '{0, 32'h1000_0040, 32'h0,         4'hF, 3'(1 << PPROT_NONSEC), 0, 0, 0, 0, 32'hDEAD_BEEF, 0, 3};
    tbl[2]  = '{1, 32'h1000_0044, 32'hFFFF_FFFF, 4'hF, 3'h0,                  0, 0, 0, 0, 32'h0,         0, 3};
    tbl[3]  = '{1, 32'h1000_0044, 32'h1122_3344, 4'h5, 3'h0,                  0, 0, 0, 0, 32'h0,         0, 3};
    tbl[4]  = '{0, 32'h1000_0044, 32'h0,         4'h0, 3'(1 << PPROT_INSTR),  0, 0, 0, 5, 32'hFF22_FF44, 0, 3};
    tbl[5]  = '{1, 32'h1000_0048, 32'hCAFE_F00D, 4'hF, 3'h7,                  3, 0, 0, 0, 32'h0,         0, 6};
    tbl[6]  = '{0, 32'h1000_0048, 32'h0,         4'h0, 3'h2,                  3, 0, 0, 0, 32'hCAFE_F00D, 0, 6};
    tbl[7]  = '{0, 32'h1000_0040, 32'h0,         4'h0, 3'h0,                  1, 1, 0, 0, 32'hDEAD_BEEF, 1, 4};
    tbl[8]  = '{1, 32'h1000_0048, 32'h1234_5678, 4'hF, 3'h0,                  0, 1, 0, 2, 32'h0,         1, 3};
    tbl[9]  = '{0, 32'h1000_0044, 32'h0,         4'h0, 3'h0,                  0, 0, 1, 0, 32'h0,         1, 2 + TO};
    tbl[10] = '{1, 32'h1000_0040, 32'h5555_AAAA, 4'hF, 3'h0,                  0, 0, 1, 0, 32'h0,         1, 2 + TO};
    tbl[11] = '{0, 32'h1000_0040, 32'h0,         4'h0, 3'h0,                  2, 0, 0, 0, 32'hDEAD_BEEF, 0, 5};

    PRESET = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0;
    req_wdata = '0; req_strb = '0; req_prot = '0; rsp_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outputs", {PSEL, PENABLE, PADDR, PWRITE, PWDATA, PSTRB, PPROT}, '0);
    chk("reset_rsp", {req_ready, rsp_valid, rsp_err, rsp_rdata}, '0);
    PRESET = 1'b0;
    #1 chk("ready_after_reset", req_ready, 1);

    foreach (tbl[i]) run_txn(tbl[i]);

    // Reset pulse while the slave is inserting wait states in ACCESS.
    @(negedge clk);
    s_waits = 20; s_err = 1'b0; s_stuck = 1'b0;
    req_valid = 1'b1; req_write = 1'b0; req_addr = BASE; req_prot = 3'h0;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_access", {PSEL, PENABLE}, 2'b11);
    #2 PRESET = 1'b1;
    #1 chk("reset_mid_access", {PSEL, PENABLE, rsp_valid, req_ready}, 4'b0000);
    @(negedge clk);
    PRESET = 1'b0;
    #1 chk("ready_after_mid_reset", req_ready, 1);
    v = '{0, BASE, 32'h0, 4'h0, 3'h0, 0, 0, 0, 1, model_mem[0], 0, 3};
    run_txn(v);

    for (int i = 0; i < 40; i++) begin
      int idx;
      idx = $urandom_range(0, 15);
      v.wr    = 1'($urandom);
      v.addr  = BASE + 32'(idx * 4);
      v.wdata = $urandom;
      v.strb  = 4'($urandom);
      v.prot  = 3'($urandom);
      v.waits = $urandom_range(0, 3);
      v.err   = ($urandom_range(0, 7) == 0);
      v.stuck = ($urandom_range(0, 15) == 0);
      v.hold  = $urandom_range(0, 3);
      if (v.stuck) begin
        v.exp_rdata = 32'h0; v.exp_err = 1'b1; v.exp_lat = 2 + TO;
      end else begin
        v.exp_rdata = v.wr ? 32'h0 : model_mem[idx];
        v.exp_err   = v.err;
        v.exp_lat   = 3 + v.waits;
      end
      run_txn(v);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/apb4_cmd_master.md
Name: apb4_cmd_master

Overview:
- APB4 initiator (requester) block. Converts single transactions from a valid/ready command port into APB4 SETUP/ACCESS sequences.
- Returns read data and error status on a valid/ready response port.
- Sits between a bridge or CPU-side command source and one APB4 slave or APB decoder, e.g. the APB4 memory slave.
- One transaction in flight at a time; includes a PREADY timeout guard.

Parameters:
- AW, 32, address width
- DW, 32, data width (multiple of 8)
- DS, DW/8, number of byte strobes
- TIMEOUT, 256, maximum consecutive ACCESS cycles with PREADY low; 0 disables the timeout
- CW, 16, width of the timeout counter (must hold TIMEOUT)

Ports:
- PCLK  in  1  clock; all logic on rising edge
- PRESET  in  1  asynchronous, active-high reset
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  AW  byte address
- req_wdata  in  DW  write data
- req_strb  in  DS  write byte strobes
- req_prot  in  3  protection bits
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response accepted
- rsp_rdata  out  DW  read data; 0 for writes and for timeouts
- rsp_err  out  1  PSLVERR or timeout
- PSEL  out  1  APB select
- PENABLE  out  1  APB enable
- PADDR  out  AW  APB address
- PWRITE  out  1  APB direction
- PWDATA  out  DW  APB write data
- PSTRB  out  DS  APB strobes
- PPROT  out  3  APB protection
- PRDATA  in  DW  APB read data
- PREADY  in  1  APB ready
- PSLVERR  in  1  APB slave error

Behaviour:
- Reset (asynchronous, while PRESET=1):
  - state returns to IDLE
  - all P* outputs, rsp_valid, rsp_rdata, rsp_err and timeout counter go to 0
  - req_ready=0
- FSM states: IDLE, SETUP, ACCESS, RESP.
- req_ready=1 only in IDLE with PRESET=0.
- IDLE: on req_valid & req_ready, register the command into PADDR, PWRITE, PWDATA, PSTRB and PPROT.
  - PSTRB is forced to 0 for reads (APB4 rule).
  - PWDATA is forced to 0 for reads.
  - PSEL=1, PENABLE=0 from the next cycle; go to SETUP.
- SETUP: lasts exactly one cycle. Set PENABLE=1; go to ACCESS. Clear the timeout counter.
- ACCESS: PSEL=PENABLE=1; PADDR, PWRITE, PWDATA, PSTRB and PPROT are held stable.
  - PREADY=1: register rsp_rdata (PRDATA for reads, 0 for writes) and rsp_err=PSLVERR. Drop PSEL and PENABLE; set rsp_valid=1; go to RESP.
  - PREADY=0: increment the counter. If TIMEOUT≠0 and the counter reaches TIMEOUT-1 with PREADY still low, complete as above with rsp_err=1 and rsp_rdata=0.
  - PSLVERR and PRDATA are ignored unless PREADY=1.
- RESP: rsp_valid, rsp_rdata and rsp_err are held until rsp_ready=1. Then rsp_valid=0 and go to IDLE.
- Address/control outputs keep their last values after completion (no toggling). PSEL=0 marks the bus idle.
- Latency with a zero-wait slave: command accepted at edge N, SETUP in cycle N+1, ACCESS in N+2, rsp_valid high in N+3.
- Throughput: at best one transaction per 4 cycles, because a new command is accepted only in IDLE.
- req_addr is passed through unaltered; alignment is the requester's responsibility.
- Reset asserted mid-transaction: PSEL and PENABLE drop at once; the pending response is discarded.
- PREADY and PSLVERR are sampled only in ACCESS. Values on them in other states have no effect.

Decomposition:
- Shared package apb4_pkg holds:
  - FSM state encoding
  - PPROT bit position constants (PRIV=0, NONSEC=1, INSTR=2)
  - default TIMEOUT value
- No sub-module: the FSM, datapath registers and timeout counter live in one module.

Test Plan:
- Write-then-read: write 0x1000_0040 with 0xDEADBEEF, strb 0xF, against a zero-wait memory slave; read back → rsp_rdata=0xDEADBEEF, rsp_err=0, rsp_valid in cycle N+3, PSTRB=0 during the read.
- Partial strobe: preload 0xFFFFFFFF, write 0x11223344 with strb 0x5, read → 0xFF22FF44.
- Wait states: slave holds PREADY low 3 cycles → ACCESS lasts 4 cycles, PADDR/PWDATA stable throughout, rsp_valid at N+6.
- Slave error and timeout:
  - Slave asserts PSLVERR with PREADY → rsp_err=1.
  - With TIMEOUT=8 and PREADY stuck low → exactly 8 ACCESS cycles, rsp_err=1, rsp_rdata=0, PSEL=0 afterwards.
- Backpressure: rsp_ready held low 5 cycles → rsp fields stable, req_ready=0, no new PSEL. The next command is accepted only after the response handshake.
- Reset during ACCESS: PRESET pulse → PSEL, PENABLE, rsp_valid=0 immediately; after release req_ready=1 and a fresh read completes normally.
